// File: rtl/hs_fifo_mcfifo_if.sv
// Handshake bundle between a channelised producer/consumer and hs_fifo_mcfifo.
interface hs_fifo_mcfifo_if #(
  parameter type DATA_TYPE    = logic,
  parameter int  NUM_CHANNELS = 4,
  parameter int  CHAN_DEPTH   = 16
);
  localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int LVL_W = $clog2(CHAN_DEPTH + 1);

  // write side
  logic                                 wvalid;
  logic [CH_W-1:0]                      wchan;
  DATA_TYPE                             wdata;
  logic                                 wlast;
  logic                                 wdrop;
  logic                                 wready;
  // read side
  logic [CH_W-1:0]                      rchan;
  logic                                 rready;
  logic                                 rvalid;
  DATA_TYPE                             rdata;
  logic                                 rlast;
  // per-channel status
  logic [NUM_CHANNELS-1:0]              rvalid_vec;
  logic [NUM_CHANNELS-1:0]              walmost_full;
  logic [NUM_CHANNELS-1:0]              ralmost_empty;
  logic [NUM_CHANNELS-1:0][LVL_W-1:0]   level;

  modport master (
    output wvalid, wchan, wdata, wlast, wdrop, rchan, rready,
    input  wready, rvalid, rdata, rlast, rvalid_vec, walmost_full, ralmost_empty, level
  );

  modport slave (
    input  wvalid, wchan, wdata, wlast, wdrop, rchan, rready,
    output wready, rvalid, rdata, rlast, rvalid_vec, walmost_full, ralmost_empty, level
  );
endinterface

// File: rtl/hs_fifo_mcfifo.sv
// Multi-channel synchronous FIFO: NUM_CHANNELS queues sharing one flop array,
// each owning a fixed CHAN_DEPTH region. Optional packet mode hides beats until
// their packet's last beat is written, and can rewind an open packet on wdrop.
module hs_fifo_mcfifo #(
  parameter type DATA_TYPE        = logic,
  parameter int  NUM_CHANNELS     = 4,
  parameter int  CHAN_DEPTH       = 16,
  parameter int  ALMOST_FULL_LVL  = CHAN_DEPTH,
  parameter int  ALMOST_EMPTY_LVL = 0,
  parameter bit  EN_PACKET_MODE   = 1'b0,
  parameter bit  EN_DROP_PACKET   = 1'b0
) (
  input logic             clk,
  input logic             aresetn,
  hs_fifo_mcfifo_if.slave fifo_if
);
  localparam int CH_W    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int LVL_W   = $clog2(CHAN_DEPTH + 1);
  localparam int PTR_W   = (CHAN_DEPTH > 1) ? $clog2(CHAN_DEPTH) : 1;
  localparam int ENTRIES = NUM_CHANNELS * CHAN_DEPTH;
  localparam int IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  // Drop only makes sense when there is an uncommitted packet to rewind.
  localparam bit DROP_EN = EN_PACKET_MODE && EN_DROP_PACKET;

  localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CH_W-1:0]  CH_ZERO  = {CH_W{1'b0}};

  // Pointer increment with wrap at CHAN_DEPTH-1 (depth need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] nxt;
    if (int'(ptr) == CHAN_DEPTH - 1) begin
      nxt = PTR_ZERO;
    end else begin
      nxt = ptr + PTR_ONE;
    end
    return nxt;
  endfunction

  // Flat storage index of a channel's slot.
  function automatic logic [IDX_W-1:0] entry_idx(input logic [CH_W-1:0] ch,
                                                 input logic [PTR_W-1:0] ptr);
    return IDX_W'(int'(ch) * CHAN_DEPTH + int'(ptr));
  endfunction

  // True when the channel number addresses an existing queue.
  function automatic logic chan_ok(input logic [CH_W-1:0] ch);
    return int'(ch) < NUM_CHANNELS;
  endfunction

  // per-channel control state
  logic [PTR_W-1:0] wptr_q    [NUM_CHANNELS];
  logic [PTR_W-1:0] wptr_d    [NUM_CHANNELS];
  logic [PTR_W-1:0] cptr_q    [NUM_CHANNELS];
  logic [PTR_W-1:0] cptr_d    [NUM_CHANNELS];
  logic [PTR_W-1:0] rptr_q    [NUM_CHANNELS];
  logic [PTR_W-1:0] rptr_d    [NUM_CHANNELS];
  logic [LVL_W-1:0] level_q   [NUM_CHANNELS];
  logic [LVL_W-1:0] level_d   [NUM_CHANNELS];
  logic [LVL_W-1:0] clevel_q  [NUM_CHANNELS];
  logic [LVL_W-1:0] clevel_d  [NUM_CHANNELS];
  logic [LVL_W-1:0] pkt_cnt_q [NUM_CHANNELS];
  logic [LVL_W-1:0] pkt_cnt_d [NUM_CHANNELS];

  // payload storage, {wlast, wdata} split into two arrays
  DATA_TYPE data_mem_q [ENTRIES];
  logic     last_mem_q [ENTRIES];

  // decoded handshake signals
  logic                               wch_ok_s;
  logic                               rch_ok_s;
  logic [CH_W-1:0]                    wch_s;
  logic [CH_W-1:0]                    rch_s;
  logic                               drop_beat_s;
  logic                               wready_s;
  logic                               rvalid_s;
  logic                               wacc_s;
  logic                               racc_s;
  logic [IDX_W-1:0]                   wr_idx_s;
  logic [IDX_W-1:0]                   rd_idx_s;
  logic                               head_last_s;
  logic [NUM_CHANNELS-1:0]            rvalid_vec_s;
  logic [NUM_CHANNELS-1:0]            walmost_full_s;
  logic [NUM_CHANNELS-1:0]            ralmost_empty_s;
  logic [NUM_CHANNELS-1:0][LVL_W-1:0] level_s;

  // Readability per channel, from registered counters only.
  always_comb begin
    rvalid_vec_s = {NUM_CHANNELS{1'b0}};
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (EN_PACKET_MODE) begin
        rvalid_vec_s[c] = (pkt_cnt_q[c] != LVL_ZERO);
      end else begin
        rvalid_vec_s[c] = (clevel_q[c] != LVL_ZERO);
      end
    end
  end

  // Channel decode, handshake qualification and head/tail addressing.
  always_comb begin
    wch_ok_s = chan_ok(fifo_if.wchan);
    rch_ok_s = chan_ok(fifo_if.rchan);
    if (wch_ok_s) begin
      wch_s = fifo_if.wchan;
    end else begin
      wch_s = CH_ZERO;
    end
    if (rch_ok_s) begin
      rch_s = fifo_if.rchan;
    end else begin
      rch_s = CH_ZERO;
    end
    drop_beat_s = DROP_EN && fifo_if.wdrop;
    // A drop-beat is never stored, so it is accepted even into a full channel.
    if (wch_ok_s) begin
      wready_s = (int'(level_q[wch_s]) < CHAN_DEPTH) || drop_beat_s;
    end else begin
      wready_s = 1'b0;
    end
    if (rch_ok_s) begin
      rvalid_s = rvalid_vec_s[rch_s];
    end else begin
      rvalid_s = 1'b0;
    end
    wacc_s      = fifo_if.wvalid && wready_s;
    racc_s      = rvalid_s && fifo_if.rready;
    wr_idx_s    = entry_idx(wch_s, wptr_q[wch_s]);
    rd_idx_s    = entry_idx(rch_s, rptr_q[rch_s]);
    head_last_s = last_mem_q[rd_idx_s];
  end

  // Per-channel pointer, occupancy and packet-count update.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      wptr_d[c]    = wptr_q[c];
      cptr_d[c]    = cptr_q[c];
      rptr_d[c]    = rptr_q[c];
      level_d[c]   = level_q[c];
      clevel_d[c]  = clevel_q[c];
      pkt_cnt_d[c] = pkt_cnt_q[c];

      if (wacc_s && (int'(wch_s) == c)) begin
        if (drop_beat_s) begin
          // Rewind to the last commit point; uncommitted span = level - clevel.
          wptr_d[c]  = cptr_q[c];
          level_d[c] = clevel_q[c];
        end else begin
          wptr_d[c]  = ptr_inc(wptr_q[c]);
          level_d[c] = level_q[c] + LVL_ONE;
          if (!EN_PACKET_MODE) begin
            cptr_d[c]   = ptr_inc(cptr_q[c]);
            clevel_d[c] = clevel_q[c] + LVL_ONE;
          end else if (fifo_if.wlast) begin
            // Everything written so far, including this beat, becomes committed.
            cptr_d[c]    = ptr_inc(wptr_q[c]);
            clevel_d[c]  = level_q[c] + LVL_ONE;
            pkt_cnt_d[c] = pkt_cnt_q[c] + LVL_ONE;
          end else begin
            cptr_d[c] = cptr_q[c];
          end
        end
      end else begin
        wptr_d[c] = wptr_q[c];
      end

      if (racc_s && (int'(rch_s) == c)) begin
        rptr_d[c]   = ptr_inc(rptr_q[c]);
        level_d[c]  = level_d[c] - LVL_ONE;
        clevel_d[c] = clevel_d[c] - LVL_ONE;
        if (EN_PACKET_MODE && head_last_s) begin
          pkt_cnt_d[c] = pkt_cnt_d[c] - LVL_ONE;
        end else begin
          pkt_cnt_d[c] = pkt_cnt_d[c];
        end
      end else begin
        rptr_d[c] = rptr_q[c];
      end
    end
  end

  // Status vectors decoded from registered state.
  always_comb begin
    walmost_full_s  = {NUM_CHANNELS{1'b0}};
    ralmost_empty_s = {NUM_CHANNELS{1'b0}};
    level_s         = {(NUM_CHANNELS*LVL_W){1'b0}};
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      walmost_full_s[c]  = int'(level_q[c]) >= ALMOST_FULL_LVL;
      ralmost_empty_s[c] = !rvalid_vec_s[c] || (int'(clevel_q[c]) <= ALMOST_EMPTY_LVL);
      level_s[c]         = level_q[c];
    end
  end

  // Drive the interface outputs.
  always_comb begin
    fifo_if.wready        = wready_s;
    fifo_if.rvalid        = rvalid_s;
    fifo_if.rdata         = data_mem_q[rd_idx_s];
    fifo_if.rlast         = head_last_s;
    fifo_if.rvalid_vec    = rvalid_vec_s;
    fifo_if.walmost_full  = walmost_full_s;
    fifo_if.ralmost_empty = ralmost_empty_s;
    fifo_if.level         = level_s;
  end

  // Control state register; synchronous active-low reset empties every queue.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        wptr_q[c]    <= PTR_ZERO;
        cptr_q[c]    <= PTR_ZERO;
        rptr_q[c]    <= PTR_ZERO;
        level_q[c]   <= LVL_ZERO;
        clevel_q[c]  <= LVL_ZERO;
        pkt_cnt_q[c] <= LVL_ZERO;
      end
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        wptr_q[c]    <= wptr_d[c];
        cptr_q[c]    <= cptr_d[c];
        rptr_q[c]    <= rptr_d[c];
        level_q[c]   <= level_d[c];
        clevel_q[c]  <= clevel_d[c];
        pkt_cnt_q[c] <= pkt_cnt_d[c];
      end
    end
  end

  // Payload storage write; not reset, pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (wacc_s && !drop_beat_s) begin
      data_mem_q[wr_idx_s] <= fifo_if.wdata;
      last_mem_q[wr_idx_s] <= fifo_if.wlast;
    end
  end
endmodule

// File: tb/tb_hs_fifo_mcfifo.sv
// Bench for hs_fifo_mcfifo: dut 0 is a plain stream FIFO, dut 1 runs packet
// mode with drop. A queue-based model is compared on every falling edge, and
// directed scenarios add hand-computed literal expectations.
module tb_hs_fifo_mcfifo;
  typedef logic [7:0] byte_t;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  int   total = 0;
  int   bad = 0;

  // per-dut stimulus
  logic       wvalid_t [2];
  logic [1:0] wchan_t  [2];
  byte_t      wdata_t  [2];
  logic       wlast_t  [2];
  logic       wdrop_t  [2];
  logic [1:0] rchan_t  [2];
  logic       rready_t [2];
  // per-dut observed outputs
  logic            wready_o [2];
  logic            rvalid_o [2];
  byte_t           rdata_o  [2];
  logic            rlast_o  [2];
  logic [3:0]      rvv_o    [2];
  logic [3:0]      af_o     [2];
  logic [3:0]      ae_o     [2];
  logic [3:0][3:0] level_o  [2];

  // model: committed and pending (uncommitted) beats {last,data}, index d*4+c
  logic [8:0] cq [8][$];
  logic [8:0] pq [8][$];

  hs_fifo_mcfifo_if #(.DATA_TYPE(byte_t), .NUM_CHANNELS(4), .CHAN_DEPTH(8)) bus_a ();
  hs_fifo_mcfifo_if #(.DATA_TYPE(byte_t), .NUM_CHANNELS(4), .CHAN_DEPTH(8)) bus_b ();

  hs_fifo_mcfifo #(.DATA_TYPE(byte_t), .NUM_CHANNELS(4), .CHAN_DEPTH(8),
                   .ALMOST_FULL_LVL(8), .ALMOST_EMPTY_LVL(0),
                   .EN_PACKET_MODE(1'b0), .EN_DROP_PACKET(1'b0))
    dut_a (.clk(clk), .aresetn(aresetn), .fifo_if(bus_a));

  hs_fifo_mcfifo #(.DATA_TYPE(byte_t), .NUM_CHANNELS(4), .CHAN_DEPTH(8),
                   .ALMOST_FULL_LVL(6), .ALMOST_EMPTY_LVL(2),
                   .EN_PACKET_MODE(1'b1), .EN_DROP_PACKET(1'b1))
    dut_b (.clk(clk), .aresetn(aresetn), .fifo_if(bus_b));

  assign bus_a.wvalid = wvalid_t[0];  assign bus_b.wvalid = wvalid_t[1];
  assign bus_a.wchan  = wchan_t[0];   assign bus_b.wchan  = wchan_t[1];
  assign bus_a.wdata  = wdata_t[0];   assign bus_b.wdata  = wdata_t[1];
  assign bus_a.wlast  = wlast_t[0];   assign bus_b.wlast  = wlast_t[1];
  assign bus_a.wdrop  = wdrop_t[0];   assign bus_b.wdrop  = wdrop_t[1];
  assign bus_a.rchan  = rchan_t[0];   assign bus_b.rchan  = rchan_t[1];
  assign bus_a.rready = rready_t[0];  assign bus_b.rready = rready_t[1];
  assign wready_o[0] = bus_a.wready;        assign wready_o[1] = bus_b.wready;
  assign rvalid_o[0] = bus_a.rvalid;        assign rvalid_o[1] = bus_b.rvalid;
  assign rdata_o[0]  = bus_a.rdata;         assign rdata_o[1]  = bus_b.rdata;
  assign rlast_o[0]  = bus_a.rlast;         assign rlast_o[1]  = bus_b.rlast;
  assign rvv_o[0]    = bus_a.rvalid_vec;    assign rvv_o[1]    = bus_b.rvalid_vec;
  assign af_o[0]     = bus_a.walmost_full;  assign af_o[1]     = bus_b.walmost_full;
  assign ae_o[0]     = bus_a.ralmost_empty; assign ae_o[1]     = bus_b.ralmost_empty;
  assign level_o[0]  = bus_a.level;         assign level_o[1]  = bus_b.level;

  always #5 clk = ~clk;

  task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", nm, d, $time, act, exp);
    end
  endtask

  // ---------------- model queries ----------------
  function automatic int m_level(input int k);
    return cq[k].size() + pq[k].size();
  endfunction

  function automatic int m_pkts(input int k);
    int n = 0;
    for (int i = 0; i < cq[k].size(); i++) if (cq[k][i][8]) n++;
    return n;
  endfunction

  function automatic bit m_rvv(input int d, input int c);
    if (d == 1) return m_pkts(d*4 + c) != 0;
    return cq[d*4 + c].size() != 0;
  endfunction

  function automatic bit m_wready(input int d);
    return (m_level(d*4 + int'(wchan_t[d])) < 8) || (d == 1 && wdrop_t[d]);
  endfunction

  function automatic bit m_rvalid(input int d);
    return m_rvv(d, int'(rchan_t[d]));
  endfunction

  // Model update on each rising edge, using pre-edge acceptance decisions.
  always @(posedge clk) begin
    if (!aresetn) begin
      for (int k = 0; k < 8; k++) begin
        cq[k].delete();
        pq[k].delete();
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        int  kw;
        int  kr;
        bit  wacc;
        bit  racc;
        kw   = d*4 + int'(wchan_t[d]);
        kr   = d*4 + int'(rchan_t[d]);
        wacc = wvalid_t[d] && m_wready(d);
        racc = m_rvalid(d) && rready_t[d];
        if (racc) void'(cq[kr].pop_front());
        if (wacc) begin
          if (d == 1 && wdrop_t[d]) begin
            pq[kw].delete();
          end else if (d == 0) begin
            cq[kw].push_back({wlast_t[d], wdata_t[d]});
          end else begin
            pq[kw].push_back({wlast_t[d], wdata_t[d]});
            if (wlast_t[d]) while (pq[kw].size() > 0) cq[kw].push_back(pq[kw].pop_front());
          end
        end
      end
    end
  end

  // Compare every DUT output with the model on each falling edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      check("wready", d, 32'(wready_o[d]), 32'(m_wready(d)));
      check("rvalid", d, 32'(rvalid_o[d]), 32'(m_rvalid(d)));
      if (m_rvalid(d)) begin
        check("rdata", d, 32'(rdata_o[d]), 32'(cq[d*4 + int'(rchan_t[d])][0][7:0]));
        check("rlast", d, 32'(rlast_o[d]), 32'(cq[d*4 + int'(rchan_t[d])][0][8]));
      end
      for (int c = 0; c < 4; c++) begin
        check("rvalid_vec", d, 32'(rvv_o[d][c]), 32'(m_rvv(d, c)));
        check("level", d, 32'(level_o[d][c]), 32'(m_level(d*4 + c)));
        check("walmost_full", d, 32'(af_o[d][c]), 32'(m_level(d*4 + c) >= ((d == 0) ? 8 : 6)));
        check("ralmost_empty", d, 32'(ae_o[d][c]),
              32'(!m_rvv(d, c) || (cq[d*4 + c].size() <= ((d == 0) ? 0 : 2))));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 2; d++) begin
      wvalid_t[d] = 1'b0; wchan_t[d] = 2'd0; wdata_t[d] = 8'h00; wlast_t[d] = 1'b0;
      wdrop_t[d]  = 1'b0; rchan_t[d] = 2'd0; rready_t[d] = 1'b0;
    end
  endtask

  task automatic wr(input int d, input logic [1:0] c, input byte_t data, input logic last);
    wvalid_t[d] = 1'b1; wchan_t[d] = c; wdata_t[d] = data; wlast_t[d] = last;
    step();
    wvalid_t[d] = 1'b0; wlast_t[d] = 1'b0;
  endtask

  task automatic rd(input int d, input logic [1:0] c, input byte_t exp_data, input logic exp_last);
    rchan_t[d] = c; rready_t[d] = 1'b1;
    #1;
    check("lit_rvalid", d, 32'(rvalid_o[d]), 32'd1);
    check("lit_rdata", d, 32'(rdata_o[d]), 32'(exp_data));
    check("lit_rlast", d, 32'(rlast_o[d]), 32'(exp_last));
    step();
    rready_t[d] = 1'b0;
  endtask

  initial begin
    idle_all();
    aresetn = 1'b0;
    step(); step();
    aresetn = 1'b1;
    #1;
    // reset state
    for (int d = 0; d < 2; d++) begin
      check("rst_level", d, 32'(level_o[d]), 32'd0);
      check("rst_rvv", d, 32'(rvv_o[d]), 32'd0);
      check("rst_ae", d, 32'(ae_o[d]), 32'hF);
      check("rst_af", d, 32'(af_o[d]), 32'h0);
      check("rst_wready", d, 32'(wready_o[d]), 32'd1);
    end

    // fill channel 2 of the stream FIFO, then drain it in order
    for (int i = 0; i < 8; i++) wr(0, 2'd2, byte_t'(8'h10 + i), 1'b0);
    wchan_t[0] = 2'd2;
    #1;
    check("full_wready", 0, 32'(wready_o[0]), 32'd0);
    check("full_level2", 0, 32'(level_o[0][2]), 32'd8);
    check("full_af2", 0, 32'(af_o[0]), 32'b0100);
    check("full_level0", 0, 32'(level_o[0][0]), 32'd0);
    for (int i = 0; i < 8; i++) rd(0, 2'd2, byte_t'(8'h10 + i), 1'b0);
    rchan_t[0] = 2'd2;
    #1;
    check("drained_rvalid", 0, 32'(rvalid_o[0]), 32'd0);

    // pointer wrap on channel 0 over three rounds
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) wr(0, 2'd0, byte_t'(8'h40 + r*8 + i), 1'b0);
      for (int i = 0; i < 6; i++) rd(0, 2'd0, byte_t'(8'h40 + r*8 + i), 1'b0);
      check("wrap_level0", 0, 32'(level_o[0][0]), 32'd0);
    end

    // full channel 1 with a concurrent read: wready stays 0 that cycle
    for (int i = 0; i < 8; i++) wr(0, 2'd1, byte_t'(8'h60 + i), 1'b0);
    wvalid_t[0] = 1'b1; wchan_t[0] = 2'd1; wdata_t[0] = 8'hEE;
    rchan_t[0] = 2'd1; rready_t[0] = 1'b1;
    #1;
    check("fullrd_wready", 0, 32'(wready_o[0]), 32'd0);
    step();
    wvalid_t[0] = 1'b0; rready_t[0] = 1'b0;
    #1;
    check("fullrd_wready_next", 0, 32'(wready_o[0]), 32'd1);
    check("fullrd_level1", 0, 32'(level_o[0][1]), 32'd7);
    for (int i = 1; i < 8; i++) rd(0, 2'd1, byte_t'(8'h60 + i), 1'b0);

    // packet mode: beats visible only after the last beat is accepted
    wr(1, 2'd3, 8'hA0, 1'b0);
    check("pkt_rvv_b1", 1, 32'(rvv_o[1][3]), 32'd0);
    wr(1, 2'd3, 8'hA1, 1'b0);
    check("pkt_rvv_b2", 1, 32'(rvv_o[1][3]), 32'd0);
    wr(1, 2'd3, 8'hA2, 1'b1);
    check("pkt_rvv_b3", 1, 32'(rvv_o[1][3]), 32'd1);
    rd(1, 2'd3, 8'hA0, 1'b0);
    rd(1, 2'd3, 8'hA1, 1'b0);
    rd(1, 2'd3, 8'hA2, 1'b1);
    check("pkt_rvv_done", 1, 32'(rvv_o[1][3]), 32'd0);

    // drop: 2-beat committed packet plus 5 uncommitted beats on channel 1
    wr(1, 2'd1, 8'hB0, 1'b0);
    wr(1, 2'd1, 8'hB1, 1'b1);
    for (int i = 0; i < 5; i++) wr(1, 2'd1, byte_t'(8'hC0 + i), 1'b0);
    check("drop_level_pre", 1, 32'(level_o[1][1]), 32'd7);
    wvalid_t[1] = 1'b1; wchan_t[1] = 2'd1; wdrop_t[1] = 1'b1; wlast_t[1] = 1'b1;
    step();
    wvalid_t[1] = 1'b0; wdrop_t[1] = 1'b0; wlast_t[1] = 1'b0;
    check("drop_level_post", 1, 32'(level_o[1][1]), 32'd2);
    for (int i = 0; i < 5; i++) wr(1, 2'd1, byte_t'(8'hC8 + i), 1'b0);
    check("drop2_level_pre", 1, 32'(level_o[1][1]), 32'd7);
    wvalid_t[1] = 1'b1; wchan_t[1] = 2'd1; wdrop_t[1] = 1'b1;
    rchan_t[1] = 2'd1; rready_t[1] = 1'b1;
    #1;
    check("droprd_rdata", 1, 32'(rdata_o[1]), 32'h0B0);
    step();
    wvalid_t[1] = 1'b0; wdrop_t[1] = 1'b0; rready_t[1] = 1'b0;
    check("droprd_level", 1, 32'(level_o[1][1]), 32'd1);
    rd(1, 2'd1, 8'hB1, 1'b1);
    check("droprd_empty", 1, 32'(level_o[1][1]), 32'd0);

    // drop recovery from a channel filled with one oversized open packet
    for (int i = 0; i < 8; i++) wr(1, 2'd0, byte_t'(8'hD0 + i), 1'b0);
    wchan_t[1] = 2'd0;
    #1;
    check("rec_wready_norm", 1, 32'(wready_o[1]), 32'd0);
    wdrop_t[1] = 1'b1;
    #1;
    check("rec_wready_drop", 1, 32'(wready_o[1]), 32'd1);
    wvalid_t[1] = 1'b1;
    step();
    wvalid_t[1] = 1'b0; wdrop_t[1] = 1'b0;
    check("rec_level0", 1, 32'(level_o[1][0]), 32'd0);

    // reset mid-packet with channel 2 holding 5 beats on both DUTs
    for (int i = 0; i < 5; i++) wr(0, 2'd2, byte_t'(8'hE0 + i), 1'b0);
    wr(1, 2'd2, 8'hF0, 1'b0);
    wr(1, 2'd2, 8'hF1, 1'b1);
    for (int i = 0; i < 3; i++) wr(1, 2'd2, byte_t'(8'hF2 + i), 1'b0);
    check("mid_level_a", 0, 32'(level_o[0][2]), 32'd5);
    check("mid_level_b", 1, 32'(level_o[1][2]), 32'd5);
    aresetn = 1'b0;
    step();
    for (int d = 0; d < 2; d++) begin
      check("mrst_level", d, 32'(level_o[d]), 32'd0);
      check("mrst_rvv", d, 32'(rvv_o[d]), 32'd0);
      check("mrst_ae", d, 32'(ae_o[d]), 32'hF);
    end
    aresetn = 1'b1;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
